uart_rx_cmd_ctrl: RTL and testbench

Command sequencer downstream of the UART receiver. Consumes the receiver's byte stream (P_DATA with a one-cycle Data_Valid pulse, plus parity and stop error flags) and decodes multi-byte commands. Executes register-file writes and reads, and hands read-back bytes to the UART transmitter. Sits in the receiver's clock domain, between the UART receiver, the register file and the UART transmitter.

---
 rtl/uart_rx_cmd_ctrl.sv | 147 ++++++++++++++
 tb/tb_uart_rx_cmd_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cmd_ctrl.sv
// UART receive-side command sequencer: decodes write/read commands into register-file strobes and read-back bytes.
// Optional inter-byte timeout enabled by defining RX_CMD_TIMEOUT_EN.
module uart_rx_cmd_ctrl #(
    parameter int          ADDR_WIDTH     = 4,
    parameter logic [7:0]  WR_OPCODE      = 8'hAA,
    parameter logic [7:0]  RD_OPCODE      = 8'hBB,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  RX_PAR_Err,
    input  logic                  RX_STP_Err,
    output logic                  RF_WrEn,
    output logic                  RF_RdEn,
    output logic [ADDR_WIDTH-1:0] RF_Address,
    output logic [7:0]            RF_WrData,
    input  logic [7:0]            RF_RdData,
    input  logic                  RF_RdData_VLD,
    output logic [7:0]            TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_Busy,
    output logic [7:0]            ERR_CNT,
    output logic                  Busy
);
    // state   | meaning
    // IDLE    | waiting for an opcode byte
    // WR_ADDR | write command, waiting for address byte
    // WR_DATA | write command, waiting for data byte
    // RD_ADDR | read command, waiting for address byte
    // RD_WAIT | read strobe issued, waiting for register-file data
    // TX_SEND | holding read-back byte until the transmitter is free
    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND} state_t;

    state_t                  state, state_nxt;
    logic                    frame_err, accepted, err_event;
    logic                    wr_en_nxt, rd_en_nxt, tx_vld_nxt;
    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic [7:0]              wr_data_nxt, tx_data_nxt;

    assign frame_err = RX_PAR_Err | RX_STP_Err;
    assign accepted  = RX_D_VLD & ~frame_err;

`ifdef RX_CMD_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMR_W-1:0] timer;
    logic             timed, timeout_hit;

    assign timed       = (state == WR_ADDR) || (state == WR_DATA) || (state == RD_ADDR) || (state == RD_WAIT);
    assign timeout_hit = timed && (timer == TMR_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_nxt   = state;
        addr_nxt    = RF_Address;
        wr_data_nxt = RF_WrData;
        tx_data_nxt = TX_P_DATA;
        wr_en_nxt   = 1'b0;
        rd_en_nxt   = 1'b0;
        tx_vld_nxt  = 1'b0;
        err_event   = frame_err;
        case (state)
            IDLE: begin
                if (accepted && RX_P_DATA == WR_OPCODE)      state_nxt = WR_ADDR;
                else if (accepted && RX_P_DATA == RD_OPCODE) state_nxt = RD_ADDR;
            end
            WR_ADDR: begin
                if (frame_err) state_nxt = IDLE;
                else if (accepted) begin
                    addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_nxt = WR_DATA;
                end
            end
            WR_DATA: begin
                if (frame_err) state_nxt = IDLE;
                else if (accepted) begin
                    wr_data_nxt = RX_P_DATA;
                    wr_en_nxt   = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            RD_ADDR: begin
                if (frame_err) state_nxt = IDLE;
                else if (accepted) begin
                    addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
                    rd_en_nxt = 1'b1;
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (accepted) err_event = 1'b1;
                if (RF_RdData_VLD) begin
                    tx_data_nxt = RF_RdData;
                    state_nxt   = TX_SEND;
                end
            end
            TX_SEND: begin
                if (accepted) err_event = 1'b1;
                if (!TX_Busy) begin
                    tx_vld_nxt = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
`ifdef RX_CMD_TIMEOUT_EN
        // A byte or a read response arriving on the terminal cycle wins over the timeout.
        if (timeout_hit && !accepted && state_nxt == state) begin
            state_nxt = IDLE;
            err_event = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            RF_WrEn    <= 1'b0;
            RF_RdEn    <= 1'b0;
            RF_Address <= '0;
            RF_WrData  <= 8'h00;
            TX_P_DATA  <= 8'h00;
            TX_D_VLD   <= 1'b0;
            ERR_CNT    <= 8'h00;
            Busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            RF_WrEn    <= wr_en_nxt;
            RF_RdEn    <= rd_en_nxt;
            RF_Address <= addr_nxt;
            RF_WrData  <= wr_data_nxt;
            TX_P_DATA  <= tx_data_nxt;
            TX_D_VLD   <= tx_vld_nxt;
            if (err_event && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
            Busy       <= (state_nxt != IDLE);
        end
    end

`ifdef RX_CMD_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              timer <= '0;
        else if (state_nxt != state || accepted) timer <= '0;
        else if (timed)                          timer <= timer + TMR_W'(1);
    end
`endif
endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Bench for uart_rx_cmd_ctrl: directed scenarios plus randomized command traffic checked against
// a transaction-level model (register array, expected error count).
module tb_uart_rx_cmd_ctrl;
`ifdef RX_CMD_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif
    logic       clk = 1'b0, rst_n = 1'b0;
    logic [7:0] RX_P_DATA = 8'h00;
    logic       RX_D_VLD = 1'b0, RX_PAR_Err = 1'b0, RX_STP_Err = 1'b0;
    logic       RF_WrEn, RF_RdEn, TX_D_VLD, Busy;
    logic [3:0] RF_Address;
    logic [7:0] RF_WrData, TX_P_DATA, ERR_CNT;
    logic [7:0] RF_RdData = 8'h00;
    logic       RF_RdData_VLD = 1'b0;
    logic       TX_Busy = 1'b0;

    uart_rx_cmd_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RX_PAR_Err(RX_PAR_Err), .RX_STP_Err(RX_STP_Err), .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn),
        .RF_Address(RF_Address), .RF_WrData(RF_WrData), .RF_RdData(RF_RdData),
        .RF_RdData_VLD(RF_RdData_VLD), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
        .TX_Busy(TX_Busy), .ERR_CNT(ERR_CNT), .Busy(Busy));

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int cyc = 0, last_vld_cyc = 0;
    int wr_cnt = 0, rd_cnt = 0, tx_cnt = 0, both_cnt = 0, tx_busy_viol = 0, wr_lat = 0;
    logic [11:0] last_wr = '0;
    logic [3:0]  last_rd_addr = '0;
    logic [7:0]  last_tx = '0;
    logic        tx_busy_prev = 1'b0;
    logic        rf_silent = 1'b0;
    logic [7:0]  rf_mem [16];
    logic [7:0]  m_regs [16];
    int          exp_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (RX_D_VLD) last_vld_cyc = cyc;
        if (RF_WrEn) begin
            wr_cnt++;
            last_wr = {RF_Address, RF_WrData};
            wr_lat  = cyc - last_vld_cyc;
            rf_mem[RF_Address] = RF_WrData;
        end
        if (RF_RdEn) begin
            rd_cnt++;
            last_rd_addr = RF_Address;
        end
        if (RF_WrEn && RF_RdEn) both_cnt++;
        if (TX_D_VLD) begin
            tx_cnt++;
            last_tx = TX_P_DATA;
            if (tx_busy_prev) tx_busy_viol++;
        end
        tx_busy_prev = TX_Busy;
    end

    // Register-file stand-in: answers a read strobe two cycles later.
    initial forever begin
        logic [3:0] a;
        @(negedge clk);
        if (RF_RdEn && !rf_silent) begin
            a = RF_Address;
            repeat (2) @(posedge clk);
            #1 RF_RdData = rf_mem[a];
            RF_RdData_VLD = 1'b1;
            @(posedge clk);
            #1 RF_RdData_VLD = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic par = 1'b0, input logic stp = 1'b0,
                             input int gap = 1);
        @(posedge clk); #1;
        RX_P_DATA = b; RX_D_VLD = 1'b1; RX_PAR_Err = par; RX_STP_Err = stp;
        @(posedge clk); #1;
        RX_D_VLD = 1'b0; RX_PAR_Err = 1'b0; RX_STP_Err = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic bump_err();
        if (exp_err < 255) exp_err++;
    endtask

    task automatic wait_tx(input string tag, input int t0);
        for (int k = 0; k < 300 && tx_cnt == t0; k++) @(posedge clk);
        #1;
        repeat (2) @(posedge clk);
        #1;
        chk(tag, tx_cnt - t0, 1);
    endtask

    initial begin
        int w0, r0, t0, bad_vld, bad_dat;
        logic [7:0] a, d, b;
        for (int i = 0; i < 16; i++) begin
            rf_mem[i] = 8'($urandom);
            m_regs[i] = rf_mem[i];
        end
        rf_mem[10] = 8'h7E; m_regs[10] = 8'h7E;
        #12;
        chk("reset_outputs", {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, TX_P_DATA, TX_D_VLD, ERR_CNT, Busy}, 0);
        @(negedge clk) rst_n = 1'b1;

        // 1: write with long gaps
        w0 = wr_cnt;
        send_byte(8'hAA, 0, 0, 80); send_byte(8'h05, 0, 0, 80); send_byte(8'h3C, 0, 0, 3);
        m_regs[5] = 8'h3C;
        chk("wr1_count", wr_cnt - w0, 1);
        chk("wr1_value", last_wr, 12'h53C);
        chk("wr1_latency", wr_lat, 1);
        chk("wr1_err", ERR_CNT, 0);

        // 2: read, transmitter idle
        r0 = rd_cnt; t0 = tx_cnt;
        send_byte(8'hBB); send_byte(8'h0A);
        wait_tx("rd2_tx_count", t0);
        chk("rd2_rd_count", rd_cnt - r0, 1);
        chk("rd2_addr", last_rd_addr, 4'hA);
        chk("rd2_tx_data", last_tx, 8'h7E);
        chk("rd2_busy", Busy, 0);

        // 3: read while transmitter busy
        TX_Busy = 1'b1; t0 = tx_cnt; bad_vld = 0; bad_dat = 0;
        send_byte(8'hBB); send_byte(8'h0A);
        repeat (5) @(posedge clk);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (TX_D_VLD) bad_vld++;
            if (TX_P_DATA !== 8'h7E) bad_dat++;
        end
        chk("busy3_no_vld", bad_vld, 0);
        chk("busy3_data_stable", bad_dat, 0);
        chk("busy3_state", Busy, 1);
        @(posedge clk); #1 TX_Busy = 1'b0;
        wait_tx("busy3_tx_count", t0);
        repeat (10) @(posedge clk);
        #1 chk("busy3_single_pulse", tx_cnt - t0, 1);

        // 4: parity error aborts a write
        w0 = wr_cnt;
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h55, 1, 0, 3);
        bump_err();
        chk("abort4_no_wr", wr_cnt - w0, 0);
        chk("abort4_idle", Busy, 0);
        chk("abort4_err", ERR_CNT, 1);
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h55, 0, 0, 3);
        m_regs[3] = 8'h55;
        chk("abort4_rewrite", last_wr, 12'h355);

        // 5: unknown opcode, opcodes as operands
        w0 = wr_cnt;
        send_byte(8'h12, 0, 0, 3);
        chk("unk5_busy", Busy, 0);
        chk("unk5_err", ERR_CNT, exp_err);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hAA, 0, 0, 3);
        m_regs[11] = 8'hAA;
        chk("opdata5_count", wr_cnt - w0, 1);
        chk("opdata5_value", last_wr, 12'hBAA);

        // Randomized traffic against the transaction model
        for (int i = 0; i < 60; i++) begin
            int kind, gap;
            kind = $urandom_range(0, 5);
            gap  = $urandom_range(0, 4);
            a = 8'($urandom);
            d = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 8'hAA : 8'hBB) : 8'($urandom);
            case (kind)
                0, 1: begin
                    w0 = wr_cnt;
                    send_byte(8'hAA, 0, 0, gap); send_byte(a, 0, 0, gap); send_byte(d, 0, 0, 3);
                    m_regs[a[3:0]] = d;
                    chk("rnd_wr_count", wr_cnt - w0, 1);
                    chk("rnd_wr_value", last_wr, {a[3:0], d});
                    chk("rnd_wr_latency", wr_lat, 1);
                end
                2: begin
                    t0 = tx_cnt;
                    TX_Busy = ($urandom_range(0, 1) == 1);
                    send_byte(8'hBB, 0, 0, gap); send_byte(a, 0, 0, 0);
                    if (TX_Busy) begin
                        repeat (4) @(posedge clk);
                        send_byte(8'hAA, 0, 0, 3);
                        bump_err();
                        @(posedge clk); #1 TX_Busy = 1'b0;
                    end
                    wait_tx("rnd_rd_tx_count", t0);
                    chk("rnd_rd_data", last_tx, m_regs[a[3:0]]);
                end
                3: begin
                    b = 8'($urandom);
                    if (b == 8'hAA || b == 8'hBB) b = 8'h00;
                    send_byte(b, 0, 0, 2);
                end
                4: begin
                    w0 = wr_cnt;
                    send_byte(8'hAA, 0, 0, gap);
                    if ($urandom_range(0, 1) == 1) send_byte(a, 0, 1, 3);
                    else begin
                        send_byte(a, 0, 0, gap);
                        send_byte(d, 1, 0, 3);
                    end
                    bump_err();
                    chk("rnd_abort_no_wr", wr_cnt - w0, 0);
                end
                default: begin
                    send_byte(8'($urandom), 1, $urandom_range(0, 1) == 1, 2);
                    bump_err();
                end
            endcase
            chk("rnd_idle", Busy, 0);
            chk("rnd_err", ERR_CNT, exp_err);
        end
        chk("strobes_exclusive", both_cnt, 0);
        chk("tx_only_when_free", tx_busy_viol, 0);

        // 6a: inter-byte timeout (or indefinite wait when the feature is absent)
        w0 = wr_cnt;
        send_byte(8'hAA, 0, 0, 40);
`ifdef RX_CMD_TIMEOUT_EN
        bump_err();
        chk("to6_idle", Busy, 0);
        chk("to6_err", ERR_CNT, exp_err);
        chk("to6_no_wr", wr_cnt - w0, 0);
`else
        chk("to6_still_waiting", Busy, 1);
        chk("to6_no_wr", wr_cnt - w0, 0);
`endif

        // 6b: reset in the middle of a read
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        exp_err = 0;
        rf_silent = 1'b1; r0 = rd_cnt;
        send_byte(8'hBB); send_byte(8'h07, 0, 0, 3);
        chk("rst6_in_rd_wait", Busy, 1);
        chk("rst6_rd_issued", rd_cnt - r0, 1);
        rst_n = 1'b0;
        #1 chk("rst6_outputs", {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, TX_P_DATA, TX_D_VLD, ERR_CNT, Busy}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        rf_silent = 1'b0; w0 = wr_cnt; r0 = rd_cnt;
        repeat (5) @(posedge clk);
        #1 chk("rst6_no_strobe", (wr_cnt - w0) + (rd_cnt - r0), 0);

        // Saturation
        for (int k = 0; k < 300; k++) send_byte(8'h00, 0, 1, 0);
        repeat (2) @(posedge clk);
        #1 chk("sat_err", ERR_CNT, 8'hFF);
        chk("sat_idle", Busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
